// File: rtl/paddle_scan_sequencer.sv
// ---------------------------------------------------------------------------
// paddle_scan_sequencer
//
// Time-shares one RC charge-time measurement engine across CHANNELS paddle
// potentiometers. Each channel in turn is discharged for DRAIN_LEN cycles and
// then allowed to recharge while a timer runs. The first threshold crossing
// that stays high for DEBOUNCE synchronized cycles is converted to an 8-bit
// position (top 8 bits of the timer). A channel that never crosses before the
// timer runs out reads as 0xFF. The result is optionally averaged with the
// previous value and published per channel.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       1 = keep scanning; 0 = stop after the current channel commits
//   measure      raw comparator/pin state per capacitor (asynchronous)
//   drain        1 = discharge that capacitor (registered)
//   values       published 8-bit value per channel, channel i at [8i+7:8i]
//   value_valid  one-cycle pulse when a channel value has been updated
//   value_ch     channel index belonging to the last value_valid pulse
// ---------------------------------------------------------------------------
module paddle_scan_sequencer #(
    parameter int CHANNELS  = 2,
    parameter int CNT_BITS  = 16,
    parameter int DRAIN_LEN = 32768,
    parameter int DEBOUNCE  = 5,
    parameter int SMOOTH    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CHANNELS-1:0]   measure,
    output logic [CHANNELS-1:0]   drain,
    output logic [8*CHANNELS-1:0] values,
    output logic                  value_valid,
    output logic [2:0]            value_ch
);

    // One timer serves both the drain interval and the charge window, so it
    // must be wide enough for whichever of the two is longer.
    localparam int DRAIN_W = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam int TMR_W   = (CNT_BITS > DRAIN_W) ? CNT_BITS : DRAIN_W;
    localparam int RUN_W   = $clog2(DEBOUNCE + 1);

    localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(DRAIN_LEN - 1);
    localparam logic [TMR_W-1:0] CHARGE_LAST = TMR_W'({CNT_BITS{1'b1}});
    localparam logic [RUN_W-1:0] RUN_DONE    = RUN_W'(DEBOUNCE);
    localparam logic [2:0]       CH_LAST     = 3'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CHARGE,
        ST_COMMIT
    } state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              ch_reg, ch_next;
    logic [TMR_W-1:0]        timer_reg, timer_next;
    logic [RUN_W-1:0]        run_reg, run_next;
    logic [7:0]              sample_reg, sample_next;

    logic [CHANNELS-1:0]     sync1_reg;
    logic [CHANNELS-1:0]     ms_reg;
    logic [CHANNELS-1:0]     drain_reg, drain_next;
    logic [8*CHANNELS-1:0]   values_reg, values_next;
    logic                    value_valid_reg;
    logic [2:0]              value_ch_reg;

    logic [7:0]              ms_wide;
    logic                    hit;
    logic [7:0]              old_value;
    logic [7:0]              smooth_value;
    logic [7:0]              commit_value;

    // Zero-pad the synchronized inputs to 8 bits so the 3-bit channel index
    // can select from it for any CHANNELS value.
    always_comb begin
        ms_wide = '0;
        ms_wide[CHANNELS-1:0] = ms_reg;
    end

    assign hit = ms_wide[ch_reg];

    // Currently published value of the selected channel.
    always_comb begin
        old_value = 8'h80;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_reg == 3'(i)) begin
                old_value = values_reg[8*i +: 8];
            end
        end
    end

    // Rounded average done 9 bits wide so 0xFF with 0xFF stays 0xFF.
    assign smooth_value = 8'(({1'b0, old_value} + {1'b0, sample_reg} + 9'd1) >> 1);
    assign commit_value = (SMOOTH != 0) ? smooth_value : sample_reg;

    // Next-state logic.
    always_comb begin
        state_next  = state_reg;
        ch_next     = ch_reg;
        timer_next  = timer_reg;
        run_next    = run_reg;
        sample_next = sample_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_DRAIN;
                    timer_next = '0;
                end
            end

            ST_DRAIN: begin
                timer_next = timer_reg + TMR_W'(1);
                if (timer_reg == DRAIN_LAST) begin
                    state_next  = ST_CHARGE;
                    timer_next  = '0;
                    run_next    = '0;
                    sample_next = 8'hFF;
                end
            end

            ST_CHARGE: begin
                timer_next = timer_reg + TMR_W'(1);
                if (hit) begin
                    // The sample is taken at the first high cycle of a run,
                    // so a confirmed crossing reports when it started.
                    if (run_reg == '0) begin
                        sample_next = timer_reg[CNT_BITS-1 -: 8];
                        run_next    = RUN_W'(1);
                    end else begin
                        run_next = run_reg + RUN_W'(1);
                    end
                end else begin
                    run_next    = '0;
                    sample_next = 8'hFF;
                end

                // Confirmation wins over timeout when both land together.
                if (run_next == RUN_DONE) begin
                    state_next = ST_COMMIT;
                end else if (timer_reg == CHARGE_LAST) begin
                    state_next  = ST_COMMIT;
                    sample_next = 8'hFF;
                end
            end

            ST_COMMIT: begin
                ch_next    = (ch_reg == CH_LAST) ? 3'd0 : ch_reg + 3'd1;
                timer_next = '0;
                state_next = enable ? ST_DRAIN : ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Per-channel drain and value update. Drain is derived from the next
    // state so the registered output lines up exactly with CHARGE.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign drain_next[gi] = !((state_next == ST_CHARGE) && (ch_next == 3'(gi)));
            assign values_next[8*gi +: 8] =
                ((state_reg == ST_COMMIT) && (ch_reg == 3'(gi))) ? commit_value
                                                                  : values_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            ch_reg          <= 3'd0;
            timer_reg       <= '0;
            run_reg         <= '0;
            sample_reg      <= 8'hFF;
            sync1_reg       <= '0;
            ms_reg          <= '0;
            drain_reg       <= '1;
            values_reg      <= {CHANNELS{8'h80}};
            value_valid_reg <= 1'b0;
            value_ch_reg    <= 3'd0;
        end else begin
            state_reg       <= state_next;
            ch_reg          <= ch_next;
            timer_reg       <= timer_next;
            run_reg         <= run_next;
            sample_reg      <= sample_next;
            sync1_reg       <= measure;
            ms_reg          <= sync1_reg;
            drain_reg       <= drain_next;
            values_reg      <= values_next;
            value_valid_reg <= (state_reg == ST_COMMIT);
            if (state_reg == ST_COMMIT) begin
                value_ch_reg <= ch_reg;
            end
        end
    end

    assign drain       = drain_reg;
    assign values      = values_reg;
    assign value_valid = value_valid_reg;
    assign value_ch    = value_ch_reg;

endmodule

// File: doc/paddle_scan_sequencer.md
Name: paddle_scan_sequencer

Overview:
- Shares one RC charge-time measurement engine between CHANNELS potentiometer inputs (paddles) by round-robin scheduling.
- For each channel in turn: discharges the capacitor, times the recharge, debounces the threshold crossing and converts the time to an 8-bit position.
- Optionally smooths the result and publishes it per channel.
- Sits between the paddle input pads (hysteresis enabled) and the game logic.

Parameters:
- CHANNELS, 2, number of paddle inputs; range 1..8.
- CNT_BITS, 16, width of the charge timer; charge window is 2^CNT_BITS cycles; sample is cnt[CNT_BITS-1 -: 8].
- DRAIN_LEN, 32768, cycles the selected capacitor is discharged before charging starts.
- DEBOUNCE, 5, consecutive synchronized-high cycles that confirm a threshold crossing.
- SMOOTH, 1, 1 = publish (old+new+1)>>1; 0 = publish raw sample.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = keep scanning; 0 = stop after the current channel's COMMIT.
- measure  in  CHANNELS  raw comparator/pin state per capacitor.
- drain  out  CHANNELS  1 = discharge that capacitor.
- values  out  8*CHANNELS  published value per channel; channel i is in bits [8i+7:8i].
- value_valid  out  1  one-cycle pulse when a channel value is updated.
- value_ch  out  3  channel index for value_valid; held until the next pulse.

Behaviour:
- Synchronizer
  - measure passes through a 2-flop synchronizer per bit.
  - Only the synchronized value (ms) is used internally.
- Reset state
  - state=IDLE, ch=0, drain=all ones, values=all 0x80, value_valid=0, value_ch=0.
  - Counters are cleared; the synchronizer is cleared to 0.
  - Reset asserted mid-operation aborts immediately with no COMMIT.
- Drain rule
  - drain[i]=0 only when state==CHARGE and i==ch; every other bit is 1 at all times.
  - drain is registered.
- IDLE: when enable=1, go to DRAIN next cycle and clear the timer.
- DRAIN
  - Timer counts 0..DRAIN_LEN-1.
  - In the cycle the timer is DRAIN_LEN-1: go to CHARGE, clear timer, clear run counter, set latched sample=0xFF.
- CHARGE
  - Timer cnt starts at 0 in the first CHARGE cycle and increments each cycle.
  - ms[ch]=1 with run==0: latch cnt[CNT_BITS-1 -: 8]; run becomes 1.
  - ms[ch]=1 with run>0: run increments.
  - ms[ch]=0: run returns to 0; latched sample returns to 0xFF.
  - run reaching DEBOUNCE → COMMIT next cycle (early exit).
  - cnt==2^CNT_BITS-1 without confirmation → COMMIT with sample=0xFF (timeout).
  - Debounce completing in the same cycle as timeout counts as confirmed; the latched sample is used.
- COMMIT (1 cycle)
  - SMOOTH=1: values[ch] <= (old+sample+1)>>1, computed 9 bits wide; 0xFF,0xFF stays 0xFF.
  - SMOOTH=0: values[ch] <= sample.
  - value_valid=1 in the following cycle, together with value_ch=ch.
  - ch advances to ch+1, wrapping CHANNELS-1→0.
  - Next state is DRAIN if enable=1, else IDLE.
- enable deasserted during DRAIN or CHARGE does not abort; the sequence finishes through COMMIT.
- CHANNELS=1: ch stays 0.

Test Plan:
- Bench params CNT_BITS=10, DRAIN_LEN=16, DEBOUNCE=3, SMOOTH=0, CHANNELS=2.
- Reset, enable=1, measure=0 → drain=2'b11 for 2+16 cycles, then drain=2'b10 during CHARGE. Timeout after 1024 cycles → values[7:0]=0xFF, value_valid pulse with value_ch=0.
- Raise measure[0] at CHARGE cycle 400 and hold → synchronized high seen at cnt=402 → sample 402>>2=100. COMMIT occurs 3 high cycles later; values[7:0]=100, value_ch=0. Channel 1 is scanned next.
- measure[1] glitch high for 2 cycles at cnt=100, then steady high from cnt=600 → glitch rejected; values[15:8]=(602>>2)=150.
- SMOOTH=1, old values[7:0]=0x80, sample 100 → (128+100+1)>>1=114.
- Drop enable during CHARGE of ch1 → COMMIT completes, then IDLE with drain=2'b11 and no further value_valid. Re-enable → scanning resumes at ch0.
- Assert reset during CHARGE → next cycle state IDLE, drain all ones, values=0x80 each, no value_valid pulse.
